// File: rtl/bp_cfg_link_endpoint_if.sv
// Config-link command/response bundle between the chip-level link (master) and one endpoint (slave).
interface bp_cfg_link_endpoint_if #(
    parameter int cfg_addr_width_p = 16,
    parameter int cfg_data_width_p = 64
);
    logic                          cfg_v_i;
    logic                          cfg_w_i;
    logic [cfg_addr_width_p-1:0]   cfg_addr_i;
    logic [cfg_data_width_p-1:0]   cfg_data_i;
    logic [cfg_data_width_p/8-1:0] cfg_mask_i;
    logic                          cfg_ready_o;
    logic                          resp_v_o;
    logic [cfg_data_width_p-1:0]   resp_data_o;
    logic                          resp_err_o;
    logic                          resp_yumi_i;

    modport master (
        output cfg_v_i, cfg_w_i, cfg_addr_i, cfg_data_i, cfg_mask_i, resp_yumi_i,
        input  cfg_ready_o, resp_v_o, resp_data_o, resp_err_o
    );
    modport slave (
        input  cfg_v_i, cfg_w_i, cfg_addr_i, cfg_data_i, cfg_mask_i, resp_yumi_i,
        output cfg_ready_o, resp_v_o, resp_data_o, resp_err_o
    );
endinterface

// File: rtl/bp_cfg_link_endpoint.sv
// Config-link register window with core reset (minimum hold) and freeze controls.
// Optional byte-masked writes are enabled with BP_CFG_LINK_BYTE_MASK_EN.
module bp_cfg_link_endpoint #(
    parameter int                          cfg_addr_width_p = 16,
    parameter int                          cfg_data_width_p = 64,
    parameter int                          num_regs_p       = 8,
    parameter logic [cfg_addr_width_p-1:0] base_addr_p      = '0,
    parameter int                          reset_hold_p     = 16
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    bp_cfg_link_endpoint_if.slave                  cfg_if,
    output logic [num_regs_p-1:0]                  reg_w_v_o,
    output logic [num_regs_p*cfg_data_width_p-1:0] reg_data_o,
    output logic                                   core_reset_o,
    output logic                                   core_freeze_o
);
    localparam int aw    = cfg_addr_width_p;
    localparam int w     = cfg_data_width_p;
    localparam int cnt_w = $clog2(reset_hold_p + 1);

    typedef enum logic {e_ready, e_resp} state_e;

    state_e                         state_r, state_n;
    logic [num_regs_p-1:0][w-1:0]   regs_r;
    logic [cnt_w-1:0]               hold_cnt_r;
    logic [w-1:0]                   resp_data_r;
    logic                           resp_err_r;
    logic [aw-1:0]                  idx;
    logic                           in_win, accept, wr_v, rst_set;
    logic [w-1:0]                   wmask, rd_data;
    logic [num_regs_p-1:0]          wr_sel;

    // Unsigned subtraction: addresses below the base wrap high and fall out of window.
    assign idx     = cfg_if.cfg_addr_i - base_addr_p;
    assign in_win  = idx < aw'(num_regs_p);
    assign accept  = cfg_if.cfg_v_i & cfg_if.cfg_ready_o;
    assign wr_v    = accept & cfg_if.cfg_w_i & in_win;
    assign rst_set = wr_sel[0] & wmask[0] & cfg_if.cfg_data_i[0];

`ifdef BP_CFG_LINK_BYTE_MASK_EN
    always_comb begin
        wmask = '0;
        for (int b = 0; b < w/8; b++) wmask[b*8 +: 8] = {8{cfg_if.cfg_mask_i[b]}};
    end
`else
    logic unused_mask;
    assign unused_mask = ^cfg_if.cfg_mask_i;
    assign wmask       = '1;
`endif

    always_comb begin
        wr_sel  = '0;
        rd_data = '0;
        for (int i = 0; i < num_regs_p; i++) begin
            if (idx == aw'(i)) begin
                wr_sel[i] = wr_v;
                rd_data   = regs_r[i];
            end
        end
        // Reset register reads back the effective reset, including the hold window.
        if (idx == '0) rd_data = w'(core_reset_o);
    end

    always_comb begin
        state_n            = state_r;
        cfg_if.cfg_ready_o = 1'b0;
        cfg_if.resp_v_o    = 1'b0;
        case (state_r)
            e_ready: begin
                cfg_if.cfg_ready_o = reset_n_i;
                if (cfg_if.cfg_v_i) state_n = e_resp;
            end
            e_resp: begin
                cfg_if.resp_v_o = 1'b1;
                if (cfg_if.resp_yumi_i) state_n = e_ready;
            end
            default: state_n = e_ready;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r     <= e_ready;
            regs_r      <= '0;
            regs_r[0]   <= w'(1);
            regs_r[1]   <= w'(1);
            hold_cnt_r  <= cnt_w'(reset_hold_p);
            resp_data_r <= '0;
            resp_err_r  <= 1'b0;
            reg_w_v_o   <= '0;
        end else begin
            state_r   <= state_n;
            reg_w_v_o <= wr_sel;
            if (accept) begin
                resp_err_r  <= ~in_win;
                resp_data_r <= (in_win && !cfg_if.cfg_w_i) ? rd_data : '0;
            end
            // Control registers keep only bit 0; general registers take the full merged word.
            for (int i = 0; i < num_regs_p; i++) begin
                if (wr_sel[i]) begin
                    if (i < 2)
                        regs_r[i] <= w'((regs_r[i][0] & ~wmask[0]) | (cfg_if.cfg_data_i[0] & wmask[0]));
                    else
                        regs_r[i] <= (regs_r[i] & ~wmask) | (cfg_if.cfg_data_i & wmask);
                end
            end
            if (rst_set)
                hold_cnt_r <= cnt_w'(reset_hold_p);
            else if (hold_cnt_r != '0)
                hold_cnt_r <= hold_cnt_r - 1'b1;
        end
    end

    // A release request is remembered in reg 0 and only takes effect once the hold expires.
    assign core_reset_o       = regs_r[0][0] | (hold_cnt_r != '0);
    assign core_freeze_o      = regs_r[1][0];
    assign reg_data_o         = regs_r;
    assign cfg_if.resp_data_o = resp_data_r;
    assign cfg_if.resp_err_o  = resp_err_r;
endmodule

// File: tb/tb_bp_cfg_link_endpoint.sv
// Randomized bench for bp_cfg_link_endpoint against a cycle-count based reference model.
module tb_bp_cfg_link_endpoint;
    localparam int          AW   = 16;
    localparam int          W    = 64;
    localparam int          NREG = 8;
    localparam int          HOLD = 16;
    localparam logic [15:0] BASE = 16'h0040;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bp_cfg_link_endpoint_if #(.cfg_addr_width_p(AW), .cfg_data_width_p(W)) ifc();

    logic [NREG-1:0]   reg_w_v;
    logic [NREG*W-1:0] reg_data;
    logic              core_reset, core_freeze;

    bp_cfg_link_endpoint #(
        .cfg_addr_width_p(AW), .cfg_data_width_p(W), .num_regs_p(NREG),
        .base_addr_p(BASE), .reset_hold_p(HOLD)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n), .cfg_if(ifc),
        .reg_w_v_o(reg_w_v), .reg_data_o(reg_data),
        .core_reset_o(core_reset), .core_freeze_o(core_freeze)
    );

    int errors = 0;
    int checks = 0;
    int cyc;

    // Reference model: reset is high while requested or until the edge count reaches hold_until.
    logic [W-1:0] m_regs [NREG];
    bit           m_req, m_frz;
    int           m_hold_until;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic bit m_core_reset(input int c);
        return m_req || (c < m_hold_until);
    endfunction

    function automatic logic [W-1:0] m_bytes(input logic [7:0] mask);
        logic [W-1:0] m;
`ifdef BP_CFG_LINK_BYTE_MASK_EN
        for (int b = 0; b < W/8; b++) m[b*8 +: 8] = {8{mask[b]}};
`else
        m = '1;
`endif
        return m;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NREG; i++) m_regs[i] = '0;
        m_req = 1'b1;
        m_frz = 1'b1;
        m_hold_until = HOLD;
    endtask

    task automatic core_chk();
        chk("core_reset", core_reset, m_core_reset(cyc));
        chk("core_freeze", core_freeze, m_frz);
    endtask

    task automatic regs_chk();
        for (int i = 2; i < NREG; i++) chk("reg_data", reg_data[i*W +: W], m_regs[i]);
    endtask

    task automatic xact(input bit wr, input logic [15:0] addr, input logic [W-1:0] data,
                        input logic [7:0] mask, input int hold);
        logic [15:0]     idx;
        bit              inw;
        logic [W-1:0]    exp_d, m;
        logic [NREG-1:0] exp_strb;
        int              e;
        @(negedge clk);
        core_chk();
        chk("ready_idle", ifc.cfg_ready_o, 1'b1);
        ifc.cfg_v_i = 1'b1; ifc.cfg_w_i = wr; ifc.cfg_addr_i = addr;
        ifc.cfg_data_i = data; ifc.cfg_mask_i = mask;
        idx = addr - BASE;
        inw = idx < NREG;
        @(posedge clk);
        #1;
        e = cyc;
        ifc.cfg_v_i = 1'b0;
        exp_d = '0;
        exp_strb = '0;
        if (inw && !wr) begin
            if (idx == 0)      exp_d = W'(m_core_reset(e - 1));
            else if (idx == 1) exp_d = W'(m_frz);
            else               exp_d = m_regs[idx];
        end
        if (inw && wr) begin
            m = m_bytes(mask);
            exp_strb[idx[2:0]] = 1'b1;
            if (idx == 0) begin
                if (m[0]) begin
                    m_req = data[0];
                    if (data[0]) m_hold_until = e + HOLD;
                end
            end else if (idx == 1) begin
                if (m[0]) m_frz = data[0];
            end else begin
                m_regs[idx] = (m_regs[idx] & ~m) | (data & m);
            end
        end
        @(negedge clk);
        chk("resp_v", ifc.resp_v_o, 1'b1);
        chk("reg_w_v", reg_w_v, exp_strb);
        for (int k = 0; k <= hold; k++) begin
            if (k > 0) begin
                @(negedge clk);
                chk("reg_w_v_off", reg_w_v, '0);
                chk("resp_v_held", ifc.resp_v_o, 1'b1);
            end
            chk("resp_err", ifc.resp_err_o, !inw);
            chk("resp_data", ifc.resp_data_o, exp_d);
            chk("ready_busy", ifc.cfg_ready_o, 1'b0);
            core_chk();
        end
        ifc.resp_yumi_i = 1'b1;
        @(posedge clk);
        #1;
        ifc.resp_yumi_i = 1'b0;
        @(negedge clk);
        chk("resp_v_done", ifc.resp_v_o, 1'b0);
        chk("ready_again", ifc.cfg_ready_o, 1'b1);
        regs_chk();
    endtask

    task automatic idle_chk(input int n);
        repeat (n) begin
            @(negedge clk);
            core_chk();
        end
    endtask

    task automatic reset_state_chk();
        chk("rst_ready", ifc.cfg_ready_o, 1'b0);
        chk("rst_resp_v", ifc.resp_v_o, 1'b0);
        chk("rst_resp_err", ifc.resp_err_o, 1'b0);
        chk("rst_resp_data", ifc.resp_data_o, '0);
        chk("rst_reg_w_v", reg_w_v, '0);
        core_chk();
        regs_chk();
    endtask

    initial begin
        logic [W-1:0] d;
        logic [15:0]  a;
        ifc.cfg_v_i = 1'b0; ifc.cfg_w_i = 1'b0; ifc.cfg_addr_i = '0;
        ifc.cfg_data_i = '0; ifc.cfg_mask_i = '0; ifc.resp_yumi_i = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        reset_state_chk();
        rst_n = 1'b1;

        // Release request right after reset: falls when the initial hold expires.
        xact(1'b1, BASE, '0, 8'hFF, 0);
        idle_chk(18);
        for (int i = 2; i < NREG; i++) xact(1'b0, BASE + 16'(i), '0, 8'h00, 0);
        xact(1'b1, BASE + 16'd3, 64'hDEAD_BEEF, 8'hFF, 0);
        xact(1'b0, BASE + 16'd3, '0, 8'h00, 1);
        chk("deadbeef", reg_data[3*W +: W], 64'hDEAD_BEEF);
        xact(1'b0, BASE + 16'd8, '0, 8'h00, 5);
        xact(1'b1, BASE + 16'd1, 64'd1, 8'hFF, 0);
        xact(1'b1, 16'h0039, 64'h1234, 8'hFF, 0);
        xact(1'b1, BASE - 16'd1, 64'h55, 8'hFF, 0);
        xact(1'b0, 16'hFFFF, '0, 8'h00, 2);
        xact(1'b0, BASE, '0, 8'h00, 0);
        // Assert then immediately request release: hold window still applies.
        xact(1'b1, BASE, 64'd1, 8'hFF, 0);
        xact(1'b1, BASE, 64'd0, 8'hFF, 0);
        xact(1'b0, BASE, '0, 8'h00, 0);
        idle_chk(20);
        xact(1'b1, BASE + 16'd2, '1, 8'hFF, 0);
        xact(1'b1, BASE + 16'd2, '0, 8'h02, 0);
        xact(1'b0, BASE + 16'd2, '0, 8'h00, 0);
`ifdef BP_CFG_LINK_BYTE_MASK_EN
        chk("byte_mask", reg_data[2*W +: W], 64'hFFFF_FFFF_FFFF_00FF);
`else
        chk("byte_mask", reg_data[2*W +: W], 64'h0);
`endif

        // Reset in the middle of a pending response.
        @(negedge clk);
        ifc.cfg_v_i = 1'b1; ifc.cfg_w_i = 1'b1; ifc.cfg_addr_i = BASE + 16'd4;
        ifc.cfg_data_i = 64'hA5A5; ifc.cfg_mask_i = 8'hFF;
        @(posedge clk);
        #1;
        ifc.cfg_v_i = 1'b0;
        @(negedge clk);
        chk("mid_resp_v", ifc.resp_v_o, 1'b1);
        rst_n = 1'b0;
        m_reset();
        #1;
        reset_state_chk();
        @(negedge clk);
        rst_n = 1'b1;
        xact(1'b0, BASE + 16'd4, '0, 8'h00, 0);

        for (int n = 0; n < 300; n++) begin
            d = {$urandom, $urandom};
            if ($urandom_range(0, 9) == 0) a = 16'($urandom);
            else                           a = BASE - 16'd2 + 16'($urandom_range(0, 11));
            xact(1'($urandom), a, d, 8'($urandom), $urandom_range(0, 3));
        end
        idle_chk(HOLD + 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
